// File: rtl/easyaxi_ar_slice.sv
// Two-entry AR channel register slice: registers valid/addr forward and ready backward.
// Optional statistics counters are built when EASYAXI_AR_SLICE_STAT_EN is defined.
module easyaxi_ar_slice #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr
`ifdef EASYAXI_AR_SLICE_STAT_EN
    ,
    input  logic                  stat_clr,
    output logic [31:0]           stat_xfer_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);

    // state | meaning
    // EMPTY | no beat held, m_arvalid low
    // ONE   | main register holds the head beat
    // TWO   | main and skid both full, upstream stalled
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic                  accept;
    logic                  drain;

    assign accept = s_arvalid && s_arready;
    assign drain  = m_arvalid && m_arready;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !drain)
                    state_nxt = TWO;
                else if (drain && !accept)
                    state_nxt = EMPTY;
            end
            TWO: if (drain) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next occupancy so neither
    // direction has a combinational path through the slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            s_arready <= 1'b0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            skid_addr <= '0;
        end else begin
            state     <= state_nxt;
            s_arready <= (state_nxt != TWO);
            m_arvalid <= (state_nxt != EMPTY);
            case (state)
                EMPTY: begin
                    if (accept) m_araddr <= s_araddr;
                end
                ONE: begin
                    if (accept && drain)
                        m_araddr <= s_araddr;
                    else if (accept)
                        skid_addr <= s_araddr;
                end
                TWO: begin
                    if (drain) m_araddr <= skid_addr;
                end
                default: ;
            endcase
        end
    end

`ifdef EASYAXI_AR_SLICE_STAT_EN
    // Clear wins over a same-cycle event; counters wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_xfer_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else if (stat_clr) begin
            stat_xfer_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (drain)
                stat_xfer_cnt <= stat_xfer_cnt + 32'd1;
            if (m_arvalid && !m_arready)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_easyaxi_ar_slice.sv
// Self-checking bench for easyaxi_ar_slice against a capacity-two FIFO model.
module tb_easyaxi_ar_slice;

    logic        clk;
    logic        rst;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
`ifdef EASYAXI_AR_SLICE_STAT_EN
    logic        stat_clr;
    logic [31:0] stat_xfer_cnt;
    logic [31:0] stat_stall_cnt;
    int          exp_xfer;
    int          exp_stall;
`endif

    int checks;
    int errors;
    logic [31:0] q[$];

    easyaxi_ar_slice #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr)
`ifdef EASYAXI_AR_SLICE_STAT_EN
        ,
        .stat_clr       (stat_clr),
        .stat_xfer_cnt  (stat_xfer_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // advance the FIFO model across the rising edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic r, output logic acc);
        logic drn;
        s_arvalid = v;
        s_araddr  = a;
        m_arready = r;
        @(negedge clk);
        checks++;
        if (m_arvalid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL m_arvalid: got %b expected %b", m_arvalid, (q.size() > 0));
        end
        checks++;
        if (s_arready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL s_arready: got %b expected %b", s_arready, (q.size() < 2));
        end
        if (q.size() > 0) begin
            checks++;
            if (m_araddr !== q[0]) begin
                errors++;
                $display("FAIL m_araddr: got %h expected %h", m_araddr, q[0]);
            end
        end
        acc = v && (q.size() < 2);
        drn = r && (q.size() > 0);
`ifdef EASYAXI_AR_SLICE_STAT_EN
        if (stat_clr) begin
            exp_xfer  = 0;
            exp_stall = 0;
        end else begin
            if (drn) exp_xfer++;
            if (q.size() > 0 && !r) exp_stall++;
        end
`endif
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(a);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic r, output int tries);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            cycle(1'b1, a, r, acc);
            tries++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: address %h not accepted after %0d cycles", a, tries);
        end
    endtask

    task automatic drain_all();
        logic acc;
        int n;
        n = 0;
        while (q.size() > 0 && n < 10) begin
            cycle(1'b0, $urandom, 1'b1, acc);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (m_arvalid !== 1'b0 || s_arready !== 1'b0 || m_araddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%b r=%b a=%h expected v=0 r=0 a=0",
                     m_arvalid, s_arready, m_araddr);
        end
        q.delete();
`ifdef EASYAXI_AR_SLICE_STAT_EN
        exp_xfer  = 0;
        exp_stall = 0;
`endif
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (s_arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: got %b expected 0", s_arready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_arready !== 1'b1 || m_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got r=%b v=%b expected r=1 v=0", s_arready, m_arvalid);
        end
    endtask

    task automatic test_reset();
        logic acc;
        do_reset();
        cycle(1'b1, 32'h55, 1'b0, acc);
        cycle(1'b1, 32'h66, 1'b0, acc);
        #2;  // mid-cycle with both entries full
        do_reset();
    endtask

    task automatic test_idle();
        logic acc;
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'hDEAD, i[0], acc);
        checks++;
        if (m_araddr !== 32'h0) begin
            errors++;
            $display("FAIL idle_capture: got %h expected 00000000", m_araddr);
        end
    endtask

    task automatic test_streaming();
        int tries;
        int stalls;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            push(32'h1000 + i, 1'b1, tries);
            if (tries != 1) stalls++;
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL stream_rate: got %0d stalled pushes expected 0", stalls);
        end
        drain_all();
    endtask

    task automatic test_backpressure();
        logic acc;
        int tries;
        push(32'hA0, 1'b0, tries);
        push(32'hA4, 1'b0, tries);
        checks++;
        if (tries != 1) begin
            errors++;
            $display("FAIL bp_second_accept: got %0d tries expected 1", tries);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hA8, 1'b0, acc);
            checks++;
            if (acc || m_araddr !== 32'hA0) begin
                errors++;
                $display("FAIL bp_hold: got acc=%b addr=%h expected acc=0 addr=000000a0", acc, m_araddr);
            end
        end
        push(32'hA8, 1'b1, tries);
        drain_all();
    endtask

    task automatic test_toggling();
        logic acc;
        logic pend;
        logic [31:0] addr;
        pend = 1'b0;
        addr = '0;
        for (int i = 0; i < 1000; i++) begin
            if (!pend) begin
                pend = $urandom_range(0, 1);
                addr = $urandom;
            end
            cycle(pend, pend ? addr : $urandom, $urandom_range(0, 1), acc);
            if (acc) pend = 1'b0;
        end
        drain_all();
        checks++;
        if (q.size() != 0 || m_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL toggle_drain: got left=%0d v=%b expected 0", q.size(), m_arvalid);
        end
    endtask

`ifdef EASYAXI_AR_SLICE_STAT_EN
    task automatic test_stat();
        logic acc;
        int tries;
        stat_clr = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, acc);
        stat_clr = 1'b0;
        cycle(1'b1, 32'hB0, 1'b0, acc);
        cycle(1'b1, 32'hB4, 1'b0, acc);
        cycle(1'b0, 32'h0, 1'b0, acc);
        cycle(1'b0, 32'h0, 1'b0, acc);
        push(32'hB8, 1'b1, tries);
        push(32'hBC, 1'b1, tries);
        push(32'hC0, 1'b1, tries);
        drain_all();
        cycle(1'b0, 32'h0, 1'b1, acc);
        checks++;
        if (stat_xfer_cnt !== 32'd5 || stat_xfer_cnt !== exp_xfer) begin
            errors++;
            $display("FAIL stat_xfer: got %0d expected 5", stat_xfer_cnt);
        end
        checks++;
        if (stat_stall_cnt !== 32'd3 || stat_stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL stat_stall: got %0d expected 3", stat_stall_cnt);
        end
        stat_clr = 1'b1;
        cycle(1'b1, 32'hC4, 1'b0, acc);
        stat_clr = 1'b0;
        checks++;
        if (stat_xfer_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stat_clr: got x=%0d s=%0d expected 0 0", stat_xfer_cnt, stat_stall_cnt);
        end
        drain_all();
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        m_arready = 1'b0;
        rst       = 1'b1;
`ifdef EASYAXI_AR_SLICE_STAT_EN
        stat_clr  = 1'b0;
`endif
        #3;
        test_reset();
        test_idle();
        test_streaming();
        test_backpressure();
        test_toggling();
`ifdef EASYAXI_AR_SLICE_STAT_EN
        test_stat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
